multdiv_sched: RTL and testbench
================================

Name: multdiv_sched

Overview:
- Sequences the shared iterative multiplier/divider for the 5-stage pipeline.
- Accepts a mult/div issue from the execute stage and latches its operands, destination and op kind.
- Fires exactly one start pulse to the multdiv unit, then holds the pipeline stall until the result returns.
- Presents the final writeback value for one cycle, applying the $rstatus exception convention (r30 = 4 for mult, 5 for div).

Parameters:
- DATA_W, 32, operand/result width.
- CNT_W, 6, width of the busy-cycle counter.
- TIMEOUT_CYCLES, 40, busy cycles before watchdog abort (used only with the optional feature).

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  execute stage holds a candidate instruction.
- issue_mult  in  1  candidate is mult.
- issue_div  in  1  candidate is div.
- issue_a  in  DATA_W  bypassed operand A.
- issue_b  in  DATA_W  bypassed operand B.
- issue_rd  in  5  destination register.
- flush  in  1  taken branch/jump; cancels the in-flight op.
- md_a  out  DATA_W  latched operand A to the multdiv unit.
- md_b  out  DATA_W  latched operand B to the multdiv unit.
- md_ctrl_mult  out  1  single-cycle start pulse, mult.
- md_ctrl_div  out  1  single-cycle start pulse, div.
- md_result  in  DATA_W  multdiv result.
- md_exception  in  1  multdiv exception; valid only with md_resultRDY.
- md_resultRDY  in  1  result ready.
- stall  out  1  freeze PC, FD, DX and XM.
- wb_valid  out  1  result is valid this cycle.
- wb_data  out  DATA_W  result, or exception code.
- wb_reg  out  5  issue_rd, or 30 on exception.
- busy_cycles  out  CNT_W  cycles spent in BUSY for the current op.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state goes to IDLE; every output is 0.
  - Any md_resultRDY that arrives later is ignored.
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - stall = 0.
  - Transitions to START when issue_valid & (issue_mult ^ issue_div) & ~flush.
  - On that transition, latch issue_a, issue_b, issue_rd and op kind; clear busy_cycles.
  - issue_mult & issue_div together is illegal: ignored, stay IDLE.
  - md_resultRDY in IDLE is ignored.
- START:
  - stall = 1.
  - Exactly one of md_ctrl_mult / md_ctrl_div is 1, for this cycle only.
  - md_a/md_b are driven from the latches and held constant until the next IDLE→START.
  - Next state is BUSY; IDLE if flush.
- BUSY:
  - stall = 1.
  - busy_cycles increments each cycle and saturates at all-ones.
  - On md_resultRDY: capture the result and go to DONE.
  - flush: go to IDLE with no wb_valid. Flush wins over a simultaneous md_resultRDY.
- DONE (one cycle):
  - stall = 0, wb_valid = 1. The still-resident mult/div instruction advances and carries wb_data.
  - issue_valid is ignored this cycle, so the same instruction is not re-issued.
  - Next state is IDLE.
- Result mapping:
  - No exception: wb_data = md_result, wb_reg = latched rd.
  - Exception: wb_data = 4 (mult) or 5 (div), wb_reg = 30.
- wb_data and wb_reg are registered and hold their value until the next DONE; they are only meaningful while wb_valid = 1.
- Minimum issue-to-wb_valid latency: 3 cycles (START, one BUSY cycle with ready, DONE).
- Back-to-back ops: the next accept happens in the IDLE cycle after DONE.

Optional Feature:
- MULTDIV_TIMEOUT_EN defined:
  - In BUSY, if busy_cycles reaches TIMEOUT_CYCLES without md_resultRDY, go to DONE as an exception (codes 4/5, wb_reg = 30).
  - timeout_err is set and remains 1 until reset.
- Undefined: BUSY waits indefinitely; timeout_err is tied to 0.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, START=1, BUSY=2, DONE=3);
  - ALU op codes MULT=5'b00110, DIV=5'b00111;
  - RSTATUS_REG=30, EXC_MULT=4, EXC_DIV=5.
- One natural sub-module: multdiv_busy_counter, a saturating counter with clear, enable and terminal-count compare used by the watchdog.
- The FSM and latches stay in the top module.

Test Plan:
- Mult, normal: issue mult a=7, b=6, rd=5; md_resultRDY with 42 two cycles after the pulse → exactly one md_ctrl_mult pulse, stall high through BUSY, wb_valid one cycle with wb_data=42, wb_reg=5.
- Div exception: issue div a=9, b=0, rd=3; ready with md_exception=1 → wb_data=5, wb_reg=30.
- Flush in BUSY: flush asserted in the 2nd BUSY cycle, ready arrives next cycle → no wb_valid, stall=0 after the flush, no extra pulse.
- No re-issue: issue_valid held high with mult through DONE → only one md_ctrl_mult pulse per op; a new div presented in the IDLE cycle after DONE gets its pulse in the following cycle.
- Reset mid-op: assert reset asynchronously (off-edge) in BUSY → all outputs 0 immediately; a later md_resultRDY produces no wb_valid.
- Watchdog (macro defined, TIMEOUT_CYCLES=40): issue mult, never assert ready → after 40 BUSY cycles wb_valid with wb_data=4, wb_reg=30, timeout_err=1 and sticky. Without the macro: stall stays high and timeout_err stays 0.

Source files
------------

// File: rtl/multdiv_sched_pkg.sv
// multdiv_sched_pkg: state encoding, ALU op codes and $rstatus constants shared by the scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multdiv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_t;

  typedef enum logic [4:0] {
    OP_MULT = 5'b00110,
    OP_DIV  = 5'b00111
  } md_op_t;

  localparam logic [4:0] RSTATUS_REG = 5'd30;
  localparam logic [2:0] EXC_MULT    = 3'd4;
  localparam logic [2:0] EXC_DIV     = 3'd5;

  // $rstatus code written back when the unit flags an exception (or the op is aborted).
  function automatic logic [2:0] exc_code(input md_op_t op);
    return (op == OP_MULT) ? EXC_MULT : EXC_DIV;
  endfunction

endpackage

// File: rtl/multdiv_busy_counter.sv
// multdiv_busy_counter: saturating busy-cycle counter with clear, enable and terminal-count flag.
// Latency: count updates on the clock edge after clear/en; tc is combinational from count and en.
// Backpressure: none; tc fires in the enabled cycle that will bring count up to TERM.
module multdiv_busy_counter #(
  parameter int CNT_W = 6,
  parameter int TERM  = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  // Count enabled cycles, sticking at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Terminal flag: this enabled cycle is the TERM-th one.
  assign tc = en && (count == CNT_W'(TERM - 1));

endmodule

// File: rtl/multdiv_sched.sv
// multdiv_sched: issues one mult/div to the shared iterative unit and writes back its result ($rstatus on exception).
// Latency: issue -> wb_valid in 3 cycles minimum (START, BUSY with ready, DONE); MULTDIV_TIMEOUT_EN adds a BUSY watchdog.
// Backpressure: stall held through START and BUSY; issue only accepted in IDLE, flush cancels the op without writeback.
module multdiv_sched
  import multdiv_sched_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 6,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_mult,
  input  logic              issue_div,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic [4:0]        issue_rd,
  input  logic              flush,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_resultRDY,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_reg,
  output logic [CNT_W-1:0]  busy_cycles,
  output logic              timeout_err
);

  md_state_t         state_q, state_d;
  md_op_t            op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [4:0]        rd_q;
  logic              accept;
  logic              capture;
  logic              cnt_en;
  logic              cnt_tc;
  logic              tmo_hit;

  assign cnt_en = (state_q == ST_BUSY);

  multdiv_busy_counter #(
    .CNT_W (CNT_W),
    .TERM  (TIMEOUT_CYCLES)
  ) u_busy_counter (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .en    (cnt_en),
    .count (busy_cycles),
    .tc    (cnt_tc)
  );

`ifdef MULTDIV_TIMEOUT_EN
  assign tmo_hit = cnt_tc;

  // Watchdog flag: set when an op is aborted for lack of a result, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (capture && !md_resultRDY) begin
      timeout_err <= 1'b1;
    end
  end
`else
  logic unused_tc;
  assign unused_tc   = cnt_tc;
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register; reset abandons any op in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the one-cycle accept/capture strobes. DONE always returns to IDLE so the
  // still-resident instruction is not re-issued; flush beats a simultaneous result.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue_valid && (issue_mult ^ issue_div) && !flush) begin
          state_d = ST_START;
          accept  = 1'b1;
        end
      end
      ST_START: begin
        state_d = flush ? ST_IDLE : ST_BUSY;
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (md_resultRDY || tmo_hit) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand/destination latches feeding the unit; held until the next accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      rd_q <= '0;
      op_q <= OP_MULT;
    end else if (accept) begin
      a_q  <= issue_a;
      b_q  <= issue_b;
      rd_q <= issue_rd;
      op_q <= issue_mult ? OP_MULT : OP_DIV;
    end
  end

  // Writeback value, captured on entry to DONE; a watchdog abort is reported like an exception.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_data <= '0;
      wb_reg  <= '0;
    end else if (capture) begin
      if (md_resultRDY && !md_exception) begin
        wb_data <= md_result;
        wb_reg  <= rd_q;
      end else begin
        wb_data <= DATA_W'(exc_code(op_q));
        wb_reg  <= RSTATUS_REG;
      end
    end
  end

  assign md_a         = a_q;
  assign md_b         = b_q;
  assign md_ctrl_mult = (state_q == ST_START) && (op_q == OP_MULT);
  assign md_ctrl_div  = (state_q == ST_START) && (op_q == OP_DIV);
  assign stall        = (state_q == ST_START) || (state_q == ST_BUSY);
  assign wb_valid     = (state_q == ST_DONE);

endmodule

// File: tb/tb_multdiv_sched.sv
// tb_multdiv_sched: directed plus randomized mult/div ops against a transaction-level expectation model.
// Latency: checks sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: stray ready/flush/issue patterns exercised around each op.
module tb_multdiv_sched;

  localparam int DATA_W         = 32;
  localparam int CNT_W          = 6;
  localparam int TIMEOUT_CYCLES = 40;

  logic              clock = 1'b0;
  logic              reset;
  logic              issue_valid, issue_mult, issue_div;
  logic [DATA_W-1:0] issue_a, issue_b;
  logic [4:0]        issue_rd;
  logic              flush;
  logic [DATA_W-1:0] md_a, md_b;
  logic              md_ctrl_mult, md_ctrl_div;
  logic [DATA_W-1:0] md_result;
  logic              md_exception, md_resultRDY;
  logic              stall, wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_reg;
  logic [CNT_W-1:0]  busy_cycles;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;
  int n_mult_pulse = 0;
  int n_div_pulse  = 0;
  int exp_mult = 0;
  int exp_div  = 0;
  bit tmo_exp  = 1'b0;
  bit at_done  = 1'b0;

  always #5 clock = ~clock;

  multdiv_sched #(
    .DATA_W (DATA_W), .CNT_W (CNT_W), .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock (clock), .reset (reset),
    .issue_valid (issue_valid), .issue_mult (issue_mult), .issue_div (issue_div),
    .issue_a (issue_a), .issue_b (issue_b), .issue_rd (issue_rd), .flush (flush),
    .md_a (md_a), .md_b (md_b), .md_ctrl_mult (md_ctrl_mult), .md_ctrl_div (md_ctrl_div),
    .md_result (md_result), .md_exception (md_exception), .md_resultRDY (md_resultRDY),
    .stall (stall), .wb_valid (wb_valid), .wb_data (wb_data), .wb_reg (wb_reg),
    .busy_cycles (busy_cycles), .timeout_err (timeout_err)
  );

  // Independent tally of start pulses seen by the unit.
  always @(negedge clock) begin
    if (md_ctrl_mult) n_mult_pulse++;
    if (md_ctrl_div)  n_div_pulse++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // What the iterative unit would compute.
  function automatic logic [31:0] unit_result(input bit m, input logic [31:0] a, input logic [31:0] b);
    if (m) return a * b;
    return (b == 0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  function automatic int sat_cnt(input int n);
    return (n > 63) ? 63 : n;
  endfunction

  // One op: wait_n = BUSY cycle carrying ready (0 = never), flush_at = cycle carrying flush
  // (-1 none, 0 START, k BUSY k), hold = keep issue_valid asserted through DONE.
  task automatic do_op(input bit m, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input int wait_n, input bit exc, input int flush_at, input bit hold);
    logic [31:0] res;
    bit flushed;
    bit fin;
    bit timed;
    bit e;
    res = unit_result(m, a, b);
    issue_valid = 1'b1; issue_mult = m; issue_div = !m;
    issue_a = a; issue_b = b; issue_rd = rd;
    if (at_done) begin
      @(negedge clock);
      chk("idle_pulse", {md_ctrl_mult, md_ctrl_div}, 0);
      chk("idle_wbv", wb_valid, 0);
    end
    chk("idle_stall", stall, 0);
    at_done = 1'b0;
    if (m) exp_mult++; else exp_div++;
    @(negedge clock);
    chk("start_pulse", {md_ctrl_mult, md_ctrl_div}, {62'd0, m, !m});
    chk("start_stall", stall, 1);
    chk("start_ops", {md_a, md_b}, {a, b});
    chk("start_cnt", busy_cycles, 0);
    if (!hold) begin
      issue_valid = 1'b0;
      issue_a = $urandom; issue_b = $urandom; issue_rd = 5'($urandom);
    end
    flushed = 1'b0;
    fin     = 1'b0;
    timed   = 1'b0;
    if (flush_at == 0) begin
      flush = 1'b1; flushed = 1'b1;
    end else begin
      for (int k = 1; k <= 200; k++) begin
        @(negedge clock);
        chk("busy_stall", stall, 1);
        chk("busy_pulse", {md_ctrl_mult, md_ctrl_div}, 0);
        chk("busy_wbv", wb_valid, 0);
        chk("busy_cnt", busy_cycles, sat_cnt(k - 1));
        chk("busy_ops", {md_a, md_b}, {a, b});
        chk("busy_tmo", timeout_err, tmo_exp);
        md_resultRDY = 1'b0; md_exception = 1'b0; md_result = $urandom;
        if (k == wait_n) begin
          md_resultRDY = 1'b1; md_exception = exc; md_result = res; fin = 1'b1;
        end
        if (k == flush_at) begin
          flush = 1'b1; flushed = 1'b1; fin = 1'b1;
        end
`ifdef MULTDIV_TIMEOUT_EN
        if (wait_n == 0 && k == TIMEOUT_CYCLES && !flushed) begin
          fin = 1'b1; timed = 1'b1;
        end
`endif
        if (fin) break;
      end
      if (!fin) chk("busy_bound", 0, 1);
    end
    @(negedge clock);
    md_resultRDY = 1'b0; md_exception = 1'b0; flush = 1'b0;
    if (flushed) begin
      chk("flush_stall", stall, 0);
      chk("flush_wbv", wb_valid, 0);
      chk("flush_pulse", {md_ctrl_mult, md_ctrl_div}, 0);
      chk("flush_cnt", busy_cycles, sat_cnt(flush_at));
      md_resultRDY = 1'b1; md_result = res;
      @(negedge clock);
      chk("late_rdy_wbv", wb_valid, 0);
      chk("late_rdy_stall", stall, 0);
      chk("late_rdy_pulse", {md_ctrl_mult, md_ctrl_div}, 0);
      md_resultRDY = 1'b0;
    end else begin
      if (timed) tmo_exp = 1'b1;
      e = exc || timed;
      chk("done_wbv", wb_valid, 1);
      chk("done_stall", stall, 0);
      chk("done_pulse", {md_ctrl_mult, md_ctrl_div}, 0);
      chk("done_data", wb_data, e ? (m ? 4 : 5) : res);
      chk("done_reg", wb_reg, e ? 30 : rd);
      chk("done_cnt", busy_cycles, timed ? TIMEOUT_CYCLES : wait_n);
      chk("done_tmo", timeout_err, tmo_exp);
      issue_valid = 1'b0;
      at_done = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    reset = 1'b1;
    issue_valid = 0; issue_mult = 0; issue_div = 0; issue_a = 0; issue_b = 0; issue_rd = 0;
    flush = 0; md_result = 0; md_exception = 0; md_resultRDY = 0;
    #1;
    chk("rst_outs", {md_a, md_b}, 0);
    chk("rst_ctrl", {md_ctrl_mult, md_ctrl_div, stall, wb_valid, timeout_err}, 0);
    chk("rst_wb", {wb_data, wb_reg, busy_cycles}, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Directed: normal mult with ready two cycles after the pulse.
    do_op(1'b1, 32'd7, 32'd6, 5'd5, 2, 1'b0, -1, 1'b0);
    // Directed: div by zero reported as exception.
    do_op(1'b0, 32'd9, 32'd0, 5'd3, 1, 1'b1, -1, 1'b0);
    // Directed: flush in the 2nd BUSY cycle, ready arrives afterwards.
    do_op(1'b1, 32'd3, 32'd4, 5'd7, 5, 1'b0, 2, 1'b0);
    // Directed: issue held through DONE, then a div presented in the following IDLE.
    do_op(1'b1, 32'd11, 32'd12, 5'd9, 1, 1'b0, -1, 1'b1);
    do_op(1'b0, 32'd100, 32'd7, 5'd4, 3, 1'b0, -1, 1'b0);

    // Directed: illegal dual-op issue and ready in IDLE are ignored; flush blocks an accept.
    if (at_done) begin @(negedge clock); at_done = 1'b0; end
    issue_valid = 1; issue_mult = 1; issue_div = 1; md_resultRDY = 1; md_result = 32'hDEAD;
    @(negedge clock);
    chk("illegal_stall", stall, 0);
    chk("illegal_pulse", {md_ctrl_mult, md_ctrl_div, wb_valid}, 0);
    issue_div = 0; md_resultRDY = 0; flush = 1;
    @(negedge clock);
    chk("flush_idle_stall", stall, 0);
    chk("flush_idle_pulse", {md_ctrl_mult, md_ctrl_div}, 0);
    issue_valid = 0; flush = 0;

    // Directed: flush in START.
    do_op(1'b0, 32'd50, 32'd5, 5'd8, 3, 1'b0, 0, 1'b0);

`ifdef MULTDIV_TIMEOUT_EN
    do_op(1'b1, 32'd2, 32'd3, 5'd12, 0, 1'b0, -1, 1'b0);
    do_op(1'b0, 32'd20, 32'd4, 5'd1, 1, 1'b0, -1, 1'b0);
`else
    // No watchdog: BUSY outlasts 40 cycles, counter saturates, then a flush recovers.
    do_op(1'b1, 32'd2, 32'd3, 5'd12, 0, 1'b0, 70, 1'b0);
`endif

    // Directed: asynchronous reset mid-op.
    if (at_done) begin @(negedge clock); at_done = 1'b0; end
    issue_valid = 1; issue_mult = 1; issue_div = 0; issue_a = 32'h55; issue_b = 32'h66; issue_rd = 5'd2;
    exp_mult++;
    @(negedge clock);
    issue_valid = 0;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    tmo_exp = 1'b0;
    chk("arst_ops", {md_a, md_b}, 0);
    chk("arst_ctrl", {md_ctrl_mult, md_ctrl_div, stall, wb_valid, timeout_err}, 0);
    chk("arst_wb", {wb_data, wb_reg, busy_cycles}, 0);
    @(negedge clock);
    reset = 1'b0;
    md_resultRDY = 1; md_result = 32'd123;
    @(negedge clock);
    chk("arst_late_wbv", wb_valid, 0);
    chk("arst_late_stall", stall, 0);
    md_resultRDY = 0;

    // Randomized ops.
    for (int i = 0; i < 25; i++) begin
      bit m, ex, hd;
      logic [31:0] ra, rb;
      int wn, fa;
      m  = 1'($urandom);
      ra = $urandom;
      rb = ($urandom % 8 == 0) ? 32'd0 : $urandom;
      wn = $urandom_range(1, 12);
      fa = ($urandom % 5 == 0) ? int'($urandom_range(0, wn)) : -1;
      ex = (!m && rb == 0) ? 1'b1 : ($urandom % 6 == 0);
      hd = (fa < 0) && ($urandom % 3 == 0);
      do_op(m, ra, rb, 5'($urandom), wn, ex, fa, hd);
    end
    if (at_done) begin @(negedge clock); at_done = 1'b0; end
    @(negedge clock);

    chk("mult_pulses", n_mult_pulse, exp_mult);
    chk("div_pulses", n_div_pulse, exp_div);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
